// File: rtl/pp_pipeline_accel_fifo_pkg.sv
// Shared defaults and sizing helper for the SRL-based pipeline FIFO.
package pp_pipeline_accel_fifo_pkg;

    localparam int unsigned DefDataWidth    = 32;
    localparam int unsigned DefDepth        = 6;
    localparam int unsigned DefAemptyThresh = 1;

    // ceil(log2(depth)); depth is at least 2, so the result is at least 1
    function automatic int unsigned calc_addr_width(input int unsigned depth);
        int unsigned w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    localparam int unsigned DefAddrWidth = calc_addr_width(DefDepth);

endpackage

// File: rtl/pp_pipeline_accel_fifo_srl_param_shiftReg.sv
// Shift-register storage: new word enters slot 0, any slot readable by address.
module pp_pipeline_accel_fifo_srl_param_shiftReg #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DEPTH      = 6
) (
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  ce,
    input  logic [ADDR_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] q
);

    localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (ce) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                mem[i] <= mem[i-1];
            end
            mem[0] <= data;
        end
    end

    // Addresses past the last slot fold to slot 0 for non-power-of-two depths
    always_comb begin
        q = mem[0];
        if (a <= LastIdx) begin
            q = mem[a];
        end
    end

endmodule

// File: rtl/pp_pipeline_accel_fifo_srl_param.sv
// Parameterised SRL FIFO with registered flags, flush, and sticky over/underflow.
module pp_pipeline_accel_fifo_srl_param
    import pp_pipeline_accel_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DefDataWidth,
    parameter int unsigned DEPTH         = DefDepth,
    parameter int unsigned ADDR_WIDTH    = calc_addr_width(DEPTH),
    parameter int unsigned AFULL_THRESH  = DEPTH - 1,
    parameter int unsigned AEMPTY_THRESH = DefAemptyThresh
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_write,
    input  logic                  if_write_ce,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read,
    input  logic                  if_read_ce,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    input  logic                  if_flush,
    output logic                  if_almost_full,
    output logic                  if_almost_empty,
    output logic                  if_overflow,
    output logic                  if_underflow,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic [ADDR_WIDTH:0]   if_fifo_cap
);

    localparam int unsigned CntW = ADDR_WIDTH + 1;

    logic [CntW-1:0]       ptr_q, ptr_d, occ_d;
    logic                  empty_n_q, empty_n_d;
    logic                  full_n_q, full_n_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  wr_req, rd_req, wa, ra, shift_ce;
    logic [ADDR_WIDTH-1:0] rd_addr;

    assign wr_req   = if_write & if_write_ce;
    assign rd_req   = if_read & if_read_ce;
    assign wa       = wr_req & full_n_q;
    assign ra       = rd_req & empty_n_q;
    // A write that coincides with flush must not disturb storage
    assign shift_ce = wa & ~if_flush;
    assign rd_addr  = ptr_q[ADDR_WIDTH] ? '0 : ptr_q[ADDR_WIDTH-1:0];

    pp_pipeline_accel_fifo_srl_param_shiftReg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_shift_reg (
        .clk  (clk),
        .data (if_din),
        .ce   (shift_ce),
        .a    (rd_addr),
        .q    (if_dout)
    );

    // ptr holds occupancy-1; all-ones means empty
    always_comb begin
        ptr_d = ptr_q;
        if (if_flush) begin
            ptr_d = '1;
        end else if (wa && !ra) begin
            ptr_d = ptr_q + 1'b1;
        end else if (ra && !wa) begin
            ptr_d = ptr_q - 1'b1;
        end
        occ_d     = ptr_d + 1'b1;
        empty_n_d = (occ_d != '0);
        full_n_d  = (occ_d != CntW'(DEPTH));
        afull_d   = (occ_d >= CntW'(AFULL_THRESH));
        aempty_d  = (occ_d <= CntW'(AEMPTY_THRESH));
        ovf_d     = if_flush ? 1'b0 : (ovf_q | (wr_req & ~full_n_q));
        unf_d     = if_flush ? 1'b0 : (unf_q | (rd_req & ~empty_n_q));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q     <= '1;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign if_empty_n        = empty_n_q;
    assign if_full_n         = full_n_q;
    assign if_almost_full    = afull_q;
    assign if_almost_empty   = aempty_q;
    assign if_overflow       = ovf_q;
    assign if_underflow      = unf_q;
    assign if_num_data_valid = ptr_q + 1'b1;
    assign if_fifo_cap       = CntW'(DEPTH);

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_srl_param.sv
// Directed vector table plus model-checked sequences for the SRL FIFO.
module tb_pp_pipeline_accel_fifo_srl_param;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_write = 1'b0, if_write_ce = 1'b0, if_read = 1'b0, if_read_ce = 1'b0;
    logic        if_flush = 1'b0;
    logic [31:0] if_din = '0;
    logic [31:0] if_dout;
    logic        if_full_n, if_empty_n, if_almost_full, if_almost_empty;
    logic        if_overflow, if_underflow;
    logic [3:0]  if_num_data_valid, if_fifo_cap;

    pp_pipeline_accel_fifo_srl_param #(
        .DATA_WIDTH    (32),
        .DEPTH         (6),
        .ADDR_WIDTH    (3),
        .AFULL_THRESH  (5),
        .AEMPTY_THRESH (1)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .if_write          (if_write),
        .if_write_ce       (if_write_ce),
        .if_din            (if_din),
        .if_full_n         (if_full_n),
        .if_read           (if_read),
        .if_read_ce        (if_read_ce),
        .if_dout           (if_dout),
        .if_empty_n        (if_empty_n),
        .if_flush          (if_flush),
        .if_almost_full    (if_almost_full),
        .if_almost_empty   (if_almost_empty),
        .if_overflow       (if_overflow),
        .if_underflow      (if_underflow),
        .if_num_data_valid (if_num_data_valid),
        .if_fifo_cap       (if_fifo_cap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w, wce;
        logic [31:0] din;
        logic        r, rce, fl;
        logic        e_n, f_n, af, ae;
        logic [3:0]  num;
        logic [31:0] dout;
        logic        ovf, unf;
    } vec_t;

    vec_t        vecs [28];
    int          total = 0;
    int          passed = 0;
    logic [31:0] mq [$];
    logic        ovf_m = 1'b0, unf_m = 1'b0;
    int          accepts = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic w, input logic wce, input logic [31:0] din,
                         input logic r, input logic rce, input logic fl);
        if_write = w; if_write_ce = wce; if_din = din;
        if_read = r; if_read_ce = rce; if_flush = fl;
    endtask

    // Drive one cycle, advance the reference queue, compare every output
    task automatic model_step(input logic w, input logic wce, input logic [31:0] din,
                              input logic r, input logic rce, input logic fl,
                              input string tag);
        logic full_m, empty_m, wa_m, ra_m;
        full_m  = (mq.size() == 6);
        empty_m = (mq.size() == 0);
        wa_m    = w & wce & ~full_m;
        ra_m    = r & rce & ~empty_m;
        @(negedge clk);
        drive(w, wce, din, r, rce, fl);
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
            ovf_m = 1'b0;
            unf_m = 1'b0;
        end else begin
            if (ra_m) void'(mq.pop_front());
            if (wa_m) mq.push_back(din);
            ovf_m = ovf_m | (w & wce & full_m);
            unf_m = unf_m | (r & rce & empty_m);
            accepts += int'(wa_m) + int'(ra_m);
        end
        check({tag, ".num"}, 64'(if_num_data_valid), 64'(mq.size()));
        check({tag, ".empty_n"}, 64'(if_empty_n), 64'(mq.size() != 0));
        check({tag, ".full_n"}, 64'(if_full_n), 64'(mq.size() != 6));
        check({tag, ".afull"}, 64'(if_almost_full), 64'(mq.size() >= 5));
        check({tag, ".aempty"}, 64'(if_almost_empty), 64'(mq.size() <= 1));
        check({tag, ".ovf"}, 64'(if_overflow), 64'(ovf_m));
        check({tag, ".unf"}, 64'(if_underflow), 64'(unf_m));
        if (mq.size() != 0) check({tag, ".dout"}, 64'(if_dout), 64'(mq[0]));
    endtask

    initial begin
        //            w  wce din        r  rce fl  e_n f_n af ae num dout       ovf unf
        vecs[0]  = '{1'b1, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 32'h11, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 32'h11, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'h11, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 32'h11, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 32'h11, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 32'h11, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 32'h11, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 32'h22, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 32'h33, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'h44, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 32'h55, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 32'h66, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0,  1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0,  1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0,  1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 32'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0,  1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0,  1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 32'hA1, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 32'hA1, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 32'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'hA1, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b1, 32'hA4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'hA2, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 1'b1, 32'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'hA3, 1'b0, 1'b0};
        vecs[22] = '{1'b1, 1'b1, 32'hA6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 32'hA3, 1'b0, 1'b0};
        vecs[23] = '{1'b1, 1'b1, 32'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0,  1'b0, 1'b0};
        vecs[24] = '{1'b1, 1'b1, 32'hC1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 32'hC1, 1'b0, 1'b0};
        vecs[25] = '{1'b1, 1'b0, 32'hC2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0,  1'b0, 1'b0};
        vecs[26] = '{1'b1, 1'b1, 32'hD1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 32'hD1, 1'b0, 1'b1};
        vecs[27] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0,  1'b0, 1'b0};

        // Reset state, held asynchronously before any clock edge matters
        #12;
        check("rst.empty_n", 64'(if_empty_n), 64'd0);
        check("rst.full_n", 64'(if_full_n), 64'd1);
        check("rst.afull", 64'(if_almost_full), 64'd0);
        check("rst.aempty", 64'(if_almost_empty), 64'd1);
        check("rst.num", 64'(if_num_data_valid), 64'd0);
        check("rst.ovf", 64'(if_overflow), 64'd0);
        check("rst.unf", 64'(if_underflow), 64'd0);
        check("cap", 64'(if_fifo_cap), 64'd6);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            @(negedge clk);
            drive(vecs[i].w, vecs[i].wce, vecs[i].din, vecs[i].r, vecs[i].rce, vecs[i].fl);
            @(posedge clk);
            #1;
            check({tag, ".empty_n"}, 64'(if_empty_n), 64'(vecs[i].e_n));
            check({tag, ".full_n"}, 64'(if_full_n), 64'(vecs[i].f_n));
            check({tag, ".afull"}, 64'(if_almost_full), 64'(vecs[i].af));
            check({tag, ".aempty"}, 64'(if_almost_empty), 64'(vecs[i].ae));
            check({tag, ".num"}, 64'(if_num_data_valid), 64'(vecs[i].num));
            check({tag, ".ovf"}, 64'(if_overflow), 64'(vecs[i].ovf));
            check({tag, ".unf"}, 64'(if_underflow), 64'(vecs[i].unf));
            if (vecs[i].e_n) check({tag, ".dout"}, 64'(if_dout), 64'(vecs[i].dout));
        end

        // Steady state at occupancy 3 with simultaneous read and write
        for (int i = 0; i < 3; i++) model_step(1, 1, 32'h100 + 32'(i), 0, 0, 0, "pre3");
        for (int i = 0; i < 10; i++) model_step(1, 1, 32'h200 + 32'(i), 1, 1, 0, "rw3");

        // Random traffic against the reference queue
        begin
            int cyc;
            cyc = 0;
            while (accepts < 10000 && cyc < 60000) begin
                model_step(($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0,
                           ($urandom_range(0, 99) < 90) ? 1'b1 : 1'b0,
                           $urandom(),
                           ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                           ($urandom_range(0, 99) < 90) ? 1'b1 : 1'b0,
                           ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                           "rand");
                cyc++;
            end
            check("rand.accept_budget", 64'(accepts >= 10000), 64'd1);
        end

        // Asynchronous reset in the middle of a burst, sampled before the next edge
        model_step(0, 0, 0, 0, 0, 1, "pre_rst_flush");
        for (int i = 0; i < 7; i++) model_step(1, 1, 32'h300 + 32'(i), 0, 0, 0, "pre_rst");
        @(negedge clk);
        drive(1, 1, 32'h3FF, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst.empty_n", 64'(if_empty_n), 64'd0);
        check("arst.full_n", 64'(if_full_n), 64'd1);
        check("arst.afull", 64'(if_almost_full), 64'd0);
        check("arst.aempty", 64'(if_almost_empty), 64'd1);
        check("arst.num", 64'(if_num_data_valid), 64'd0);
        check("arst.ovf", 64'(if_overflow), 64'd0);
        mq.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        model_step(1, 1, 32'h400, 0, 0, 0, "post_rst");
        model_step(1, 1, 32'h401, 1, 1, 0, "post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pp_pipeline_accel_fifo_srl_param.md
PP_PIPELINE_ACCEL_FIFO_SRL_PARAM -- requirements
Module: pp_pipeline_accel_fifo_srl_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 6, storage entries (2..256).
REQ-003 SHALL have parameter ADDR_WIDTH, default 3, equal to ceil(log2(DEPTH)).
REQ-004 SHALL have parameter AFULL_THRESH, default DEPTH-1, almost-full level (1..DEPTH).
REQ-005 SHALL have parameter AEMPTY_THRESH, default 1, almost-empty level (0..DEPTH-1).
REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port if_write, input, 1, write request.
REQ-009 SHALL have port if_write_ce, input, 1, write clock-enable, ANDed with if_write.
REQ-010 SHALL have port if_din, input, DATA_WIDTH, write data.
REQ-011 SHALL have port if_full_n, output, 1, 1 = space available.
REQ-012 SHALL have port if_read, input, 1, read request.
REQ-013 SHALL have port if_read_ce, input, 1, read clock-enable, ANDed with if_read.
REQ-014 SHALL have port if_dout, output, DATA_WIDTH, oldest entry, valid while if_empty_n=1.
REQ-015 SHALL have port if_empty_n, output, 1, 1 = data available.
REQ-016 SHALL have port if_flush, input, 1, synchronous discard of all contents.
REQ-017 SHALL have port if_almost_full, output, 1, occupancy >= AFULL_THRESH.
REQ-018 SHALL have port if_almost_empty, output, 1, occupancy <= AEMPTY_THRESH.
REQ-019 SHALL have port if_overflow, output, 1, sticky flag: write attempted while full.
REQ-020 SHALL have port if_underflow, output, 1, sticky flag: read attempted while empty.
REQ-021 SHALL have port if_num_data_valid, output, ADDR_WIDTH+1, current occupancy.
REQ-022 SHALL have port if_fifo_cap, output, ADDR_WIDTH+1, constant DEPTH.

Function
REQ-023 Write accept (wa) SHALL be if_write & if_write_ce & if_full_n; read accept (ra) SHALL be if_read & if_read_ce & if_empty_n.
REQ-024 Storage SHALL be a shift register: on wa, all entries shift by one and if_din enters slot 0.
REQ-025 Read pointer ptr (ADDR_WIDTH+1 bits) SHALL hold occupancy-1, with all-ones meaning empty.
REQ-026 if_dout SHALL equal slot ptr combinationally when ptr MSB=0, and slot 0 otherwise.
REQ-027 The pointer SHALL update as follows: wa only -> ptr+1; ra only -> ptr-1; wa & ra -> ptr unchanged with shift still performed; neither -> hold.
REQ-028 if_empty_n, if_full_n, if_almost_full and if_almost_empty SHALL be registered values derived from the next occupancy, so all flags are valid the cycle after an accept.
REQ-029 Write-to-read latency SHALL be one cycle: if_empty_n=1 and if_dout valid in the cycle after the first wa.
REQ-030 if_full_n SHALL drop in the cycle after the wa that brings occupancy to DEPTH; if_empty_n SHALL drop in the cycle after the ra that brings occupancy to 0.
REQ-031 A write while full or a read while empty SHALL be ignored (no state change) and SHALL set if_overflow or if_underflow respectively.
REQ-032 Flush SHALL have priority over all accepts: on if_flush=1, next state is ptr all-ones, empty_n=0, full_n=1, almost_empty=1, almost_full=0, both sticky flags cleared, and any same-cycle write is dropped.
REQ-033 if_num_data_valid SHALL equal ptr+1 (modulo 2^(ADDR_WIDTH+1)).

Reset
REQ-034 When reset_n=0, the block SHALL asynchronously set ptr to all-ones, if_empty_n=0, if_full_n=1, if_almost_empty=1, if_almost_full=0, and if_overflow=if_underflow=0.
REQ-035 Storage contents SHALL NOT be reset.
REQ-036 Deassertion of reset_n SHALL be synchronised externally; the first accept is permitted on the first clk edge after release.

Structure
REQ-037 The storage SHALL be the sub-module pp_pipeline_accel_fifo_srl_param_shiftReg, with ports clk, data, ce, a, q and parameters DATA_WIDTH, ADDR_WIDTH, DEPTH.
REQ-038 A shared package pp_pipeline_accel_fifo_pkg SHALL hold the default parameter constants and a function that computes ADDR_WIDTH from DEPTH.

Verification (DATA_WIDTH=32, DEPTH=6, AFULL_THRESH=5, AEMPTY_THRESH=1)
REQ-039 Write 0x11..0x66 with no reads -> if_full_n=0 after the 6th wa, if_almost_full=1 after the 5th, if_num_data_valid=6; six reads return 0x11..0x66 in order, then if_empty_n=0.
REQ-040 Occupancy 3, simultaneous wa and ra for 10 cycles -> if_num_data_valid stays 3 and output is in-order with no loss.
REQ-041 Write while full and read while empty -> contents unchanged, if_overflow=1 and if_underflow=1, both held until flush or reset.
REQ-042 Occupancy 4 with if_flush and if_write both high -> next cycle occupancy 0, if_empty_n=0, written word discarded.
REQ-043 reset_n asserted mid-burst between clock edges -> flags take reset values immediately, before the next clk edge.
REQ-044 Random traffic with 10k accepts, checked against a reference queue model -> zero data mismatches and flags consistent with occupancy every cycle.
